// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue: the predicted
// packet layout and the default queue geometry.
package inst_queue_pkg;

  localparam int IQ_DEPTH    = 16;
  localparam int IQ_PTR_BITS = $clog2(IQ_DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
    logic [31:0] target_pc;
    logic [9:0]  gshare_index;
    logic [1:0]  gshare_state;
    logic        pred_taken;
  } br_pred_t;

endpackage

// File: rtl/inst_queue.sv
// Circular FIFO of predicted fetch packets between the branch predictor and
// decode. Head entry is read combinationally; flush empties the queue.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   enq_valid,
  input  br_pred_t               enq_data,
  output logic                   enq_space,
  output logic                   deq_valid,
  output br_pred_t               deq_data,
  input  logic                   deq_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  br_pred_t         mem_q [DEPTH];
  logic             empty_s, full_s, enq_fire_s, deq_fire_s;

  // The MSB of each pointer is a wrap bit, so equal indices mean full or empty.
  always_comb begin
    empty_s    = (wptr_q == rptr_q);
    full_s     = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                 (wptr_q[IDX_W] != rptr_q[IDX_W]);
    enq_fire_s = enq_valid && !full_s;
    deq_fire_s = deq_ready && !empty_s;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (enq_fire_s) wptr_d = wptr_q + PTR_W'(1);
      if (deq_fire_s) rptr_d = rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && enq_fire_s) mem_q[wptr_q[IDX_W-1:0]] <= enq_data;
  end

  // Head is driven to zero when empty so decode never sees stale storage.
  always_comb begin
    deq_data = '0;
    if (!empty_s) deq_data = mem_q[rptr_q[IDX_W-1:0]];
  end

  assign enq_space = !full_s;
  assign deq_valid = !empty_s;
  assign count     = wptr_q - rptr_q;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a reference queue follows accepted
// enqueues/dequeues and every cycle's outputs are compared against it.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = IQ_DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          enq_valid = 1'b0;
  br_pred_t      enq_data = '0;
  logic          enq_space;
  logic          deq_valid;
  br_pred_t      deq_data;
  logic          deq_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;

  int            n_checks = 0;
  int            n_fail   = 0;
  longint        order_cnt = 0;
  br_pred_t      sb_q [$];
  bit            do_enq;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_space (enq_space),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_ready (deq_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pushes at the edge where the DUT accepts, pops on handshake.
  always @(posedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      do_enq = enq_valid && (sb_q.size() < DEPTH);
      if (deq_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      if (do_enq) sb_q.push_back(enq_data);
    end
  end

  // Mid-cycle comparison of every output against the reference queue.
  always @(negedge clk) begin
    if (!rst) begin
      check("count", 256'(count), 256'(sb_q.size()));
      check("deq_valid", 256'(deq_valid), 256'(sb_q.size() != 0));
      check("enq_space", 256'(enq_space), 256'(sb_q.size() < DEPTH));
      if (sb_q.size() != 0) check("head", 256'(deq_data), 256'(sb_q[0]));
      else                  check("deq_data_zero", 256'(deq_data), 256'(0));
      if (enq_valid && !flush) check("enq_while_full", 256'(enq_space), 256'(1));
    end
  end

  function automatic br_pred_t mk_pkt(input logic [31:0] pc, input longint ord);
    br_pred_t p;
    p.pc           = pc;
    p.inst         = pc ^ 32'hDEAD_BEEF;
    p.order        = ord;
    p.target_pc    = pc + 32'd8;
    p.gshare_index = pc[11:2];
    p.gshare_state = pc[3:2];
    p.pred_taken   = pc[2];
    return p;
  endfunction

  task automatic step(input bit ev, input logic [31:0] pc, input bit dr, input bit fl);
    enq_valid = ev;
    enq_data  = ev ? mk_pkt(pc, order_cnt) : '0;
    if (ev) order_cnt++;
    deq_ready = dr;
    flush     = fl;
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_count", 256'(count), 256'(0));
    check("rst_deq_valid", 256'(deq_valid), 256'(0));
    check("rst_enq_space", 256'(enq_space), 256'(1));
    check("rst_deq_data", 256'(deq_data), 256'(0));

    // Fill to full, then drain in order
    for (int i = 0; i < 16; i++) step(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
    check("full_count", 256'(count), 256'(16));
    check("full_enq_space", 256'(enq_space), 256'(0));
    for (int i = 0; i < 16; i++) begin
      check("drain_pc", 256'(deq_data.pc), 256'(32'h1000 + 32'(4 * i)));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("drained_count", 256'(count), 256'(0));

    // Index wrap-around
    for (int i = 0; i < 10; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 32'h3100 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("wrap_pc", 256'(deq_data.pc), 256'(32'h3100 + 32'(4 * i)));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("wrap_count", 256'(count), 256'(0));

    // Steady enq+deq at occupancy 5
    for (int i = 0; i < 5; i++) step(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h4100 + 32'(4 * i), 1'b1, 1'b0);
      check("steady_count", 256'(count), 256'(5));
    end
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with simultaneous enq and deq
    for (int i = 0; i < 8; i++) step(1'b1, 32'h5000 + 32'(4 * i), 1'b0, 1'b0);
    check("pre_flush_count", 256'(count), 256'(8));
    step(1'b1, 32'h5555, 1'b1, 1'b1);
    check("flush_count", 256'(count), 256'(0));
    check("flush_deq_valid", 256'(deq_valid), 256'(0));
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
    check("post_flush_deq_valid", 256'(deq_valid), 256'(0));

    // No bypass on empty, then one-cycle load-to-use
    enq_valid = 1'b1;
    enq_data  = mk_pkt(32'h2000, order_cnt);
    order_cnt++;
    #1;
    check("nobypass_deq_valid", 256'(deq_valid), 256'(0));
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    enq_data  = '0;
    check("l2u_deq_valid", 256'(deq_valid), 256'(1));
    check("l2u_pc", 256'(deq_data.pc), 256'(32'h2000));
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Full queue, single dequeue reopens space next cycle
    for (int i = 0; i < 16; i++) step(1'b1, 32'h6000 + 32'(4 * i), 1'b0, 1'b0);
    check("full2_enq_space", 256'(enq_space), 256'(0));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("reopen_enq_space", 256'(enq_space), 256'(1));
    check("reopen_count", 256'(count), 256'(15));
    check("reopen_head", 256'(deq_data.pc), 256'(32'h6004));
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("final_count", 256'(count), 256'(0));

    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
